// File: rtl/fnd_scan_decoder.sv
// rtl/fnd_scan_decoder.sv - decodes a scanned 4-digit 7-segment display bus back into a BCD frame
//
// Observes the multiplexed digit-select / segment lines of a common-anode
// 7-segment display and rebuilds the displayed 4-digit value.
//
// Ports:
//   i_clk          sole clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_digit[3:0]   digit select, active-low one-hot (bit n = digit n)
//   i_fndFont[7:0] segments, active-low (bit0=a .. bit6=g, bit7=dp)
//   o_value[15:0]  BCD frame, digit n in [4n+3:4n]
//   o_dp[3:0]      decimal point lit per digit
//   o_blank[3:0]   digit showed no segments
//   o_frameValid   one-cycle pulse when o_value/o_dp/o_blank update
//   o_fontErr      one-cycle pulse when an undecodable pattern is captured
//   o_stale        no frame completed within TIMEOUT_CYCLES

module fnd_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_digit,
  input  logic [7:0]  i_fndFont,
  output logic [15:0] o_value,
  output logic [3:0]  o_dp,
  output logic [3:0]  o_blank,
  output logic        o_frameValid,
  output logic        o_fontErr,
  output logic        o_stale
);

  localparam logic [3:0]  STABLE_MAX  = 4'(STABLE_CYCLES);
  localparam logic [19:0] TIMEOUT_MAX = 20'(TIMEOUT_CYCLES);

  // input stage and the sample before it
  logic [3:0]  digit_q, prev_digit_q;
  logic [7:0]  font_q, prev_font_q;

  // stability tracking
  logic [3:0]  stab_q, stab_d;
  logic        sample_valid;
  logic        sample_same;
  logic        capture;
  logic [1:0]  digit_idx;

  // segment decode
  logic [6:0]  seg_on;
  logic [3:0]  dec_value;
  logic        dec_ok;
  logic        dec_blank;

  // per-digit shadows and capture mask
  logic [15:0] value_sh_q, value_sh_d;
  logic [3:0]  dp_sh_q, dp_sh_d;
  logic [3:0]  blank_sh_q, blank_sh_d;
  logic [3:0]  mask_q, mask_d;
  logic        frame_fire;
  logic        font_err_d;

  // output registers
  logic [15:0] value_q;
  logic [3:0]  dp_q;
  logic [3:0]  blank_q;
  logic        frame_valid_q;
  logic        font_err_q;

  // idle / timeout counter
  logic [19:0] idle_q, idle_d;

  always_comb begin
    sample_valid = 1'b0;
    digit_idx    = 2'd0;
    case (digit_q)
      4'b1110: begin sample_valid = 1'b1; digit_idx = 2'd0; end
      4'b1101: begin sample_valid = 1'b1; digit_idx = 2'd1; end
      4'b1011: begin sample_valid = 1'b1; digit_idx = 2'd2; end
      4'b0111: begin sample_valid = 1'b1; digit_idx = 2'd3; end
      default: begin sample_valid = 1'b0; digit_idx = 2'd0; end
    endcase

    sample_same = (digit_q == prev_digit_q) && (font_q == prev_font_q);

    if (!sample_valid) begin
      stab_d = 4'd0;
    end else if (!sample_same) begin
      stab_d = 4'd1;
    end else if (stab_q != STABLE_MAX) begin
      stab_d = stab_q + 4'd1;
    end else begin
      stab_d = stab_q;
    end

    // Fires only on the step from STABLE-1 to STABLE, so a saturated run
    // never re-captures.
    capture = sample_valid && sample_same && (stab_q == STABLE_MAX - 4'd1);
  end

  always_comb begin
    seg_on    = ~font_q[6:0];
    dec_value = 4'd0;
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    case (seg_on)
      7'h3F:   dec_value = 4'd0;
      7'h06:   dec_value = 4'd1;
      7'h5B:   dec_value = 4'd2;
      7'h4F:   dec_value = 4'd3;
      7'h66:   dec_value = 4'd4;
      7'h6D:   dec_value = 4'd5;
      7'h7D:   dec_value = 4'd6;
      7'h07:   dec_value = 4'd7;
      7'h7F:   dec_value = 4'd8;
      7'h6F:   dec_value = 4'd9;
      7'h00:   dec_blank = 1'b1;
      default: dec_ok    = 1'b0;
    endcase
  end

  always_comb begin
    frame_fire = (mask_q == 4'hF);
    value_sh_d = value_sh_q;
    dp_sh_d    = dp_sh_q;
    blank_sh_d = blank_sh_q;
    mask_d     = frame_fire ? 4'h0 : mask_q;

    if (capture && dec_ok) begin
      value_sh_d[{digit_idx, 2'b00} +: 4] = dec_value;
      dp_sh_d[digit_idx]                  = ~font_q[7];
      blank_sh_d[digit_idx]               = dec_blank;
      mask_d[digit_idx]                   = 1'b1;
    end

    font_err_d = capture && !dec_ok;

    // Cleared on the edge that raises o_frameValid, so the counter (and
    // o_stale) is already zero during the pulse; a frame beats a timeout.
    if (frame_fire) begin
      idle_d = 20'd0;
    end else if (idle_q != TIMEOUT_MAX) begin
      idle_d = idle_q + 20'd1;
    end else begin
      idle_d = idle_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      digit_q       <= 4'hF;
      font_q        <= 8'hFF;
      prev_digit_q  <= 4'hF;
      prev_font_q   <= 8'hFF;
      stab_q        <= 4'd0;
      value_sh_q    <= 16'h0000;
      dp_sh_q       <= 4'h0;
      blank_sh_q    <= 4'h0;
      mask_q        <= 4'h0;
      value_q       <= 16'h0000;
      dp_q          <= 4'h0;
      blank_q       <= 4'hF;
      frame_valid_q <= 1'b0;
      font_err_q    <= 1'b0;
      idle_q        <= 20'd0;
    end else begin
      digit_q       <= i_digit;
      font_q        <= i_fndFont;
      prev_digit_q  <= digit_q;
      prev_font_q   <= font_q;
      stab_q        <= stab_d;
      value_sh_q    <= value_sh_d;
      dp_sh_q       <= dp_sh_d;
      blank_sh_q    <= blank_sh_d;
      mask_q        <= mask_d;
      frame_valid_q <= frame_fire;
      font_err_q    <= font_err_d;
      idle_q        <= idle_d;
      if (frame_fire) begin
        value_q <= value_sh_q;
        dp_q    <= dp_sh_q;
        blank_q <= blank_sh_q;
      end
    end
  end

  assign o_value      = value_q;
  assign o_dp         = dp_q;
  assign o_blank      = blank_q;
  assign o_frameValid = frame_valid_q;
  assign o_fontErr    = font_err_q;
  assign o_stale      = (idle_q == TIMEOUT_MAX);

endmodule

// File: doc/fnd_scan_decoder.md
FND_SCAN_DECODER -- requirements
Module: fnd_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive identical samples required to capture a digit (legal 2..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, SHALL set the cycles without a completed frame before o_stale asserts (legal 1..2^20-1).
REQ-003 i_clk  input  1  sole clock, all state on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_digit  input  4  scanned digit select, active-low one-hot, bit n = digit n.
REQ-006 i_fndFont  input  8  segment bus, active-low, bit0=a .. bit6=g, bit7=dp.
REQ-007 o_value  output  16  BCD frame, digit n in bits [4n+3:4n].
REQ-008 o_dp  output  4  decimal-point state per digit, 1 = lit.
REQ-009 o_blank  output  4  1 = digit was blank (all a..g off).
REQ-010 o_frameValid  output  1  one-cycle pulse when o_value/o_dp/o_blank update.
REQ-011 o_fontErr  output  1  one-cycle pulse on capture of an undecodable pattern.
REQ-012 o_stale  output  1  level, no frame completed within TIMEOUT_CYCLES.

Function
REQ-013 The block SHALL register i_digit and i_fndFont once (input stage, 1 cycle) before any comparison.
REQ-014 A registered sample SHALL be valid only if i_digit has exactly one bit low; all-high or multi-low samples SHALL clear the stability counter to 0.
REQ-015 The stability counter SHALL be 1 on a valid sample differing from the previous sample, increment on a valid identical sample, and saturate at STABLE_CYCLES.
REQ-016 Capture SHALL occur exactly once per stable run, in the cycle the counter reaches STABLE_CYCLES.
REQ-017 Decode of inverted font[6:0] SHALL be: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 00->blank (value 0, blank=1).
REQ-018 Valid capture SHALL write value, dp (= ~font[7]) and blank into the digit's shadow register and set its bit in a 4-bit capture mask.
REQ-019 Any other a..g pattern SHALL pulse o_fontErr in the cycle after capture and leave that digit's shadow and mask bit unchanged.
REQ-020 Recapture of a digit already in the mask SHALL overwrite its shadow; mask unchanged.
REQ-021 The cycle after a capture makes the mask 4'b1111, the block SHALL copy all shadows to o_value/o_dp/o_blank, pulse o_frameValid, and clear the mask.
REQ-022 Outputs o_value/o_dp/o_blank SHALL hold between frames.
REQ-023 A 20-bit idle counter SHALL clear on o_frameValid, else increment, saturating at TIMEOUT_CYCLES; o_stale = (counter == TIMEOUT_CYCLES).
REQ-024 Frame completion and timeout in the same cycle: frame SHALL win; counter cleared, o_stale 0.
REQ-025 Minimum latency from a new stable pattern on the pins to its capture SHALL be STABLE_CYCLES+1 cycles.

Reset
REQ-026 On i_reset high, asynchronously: o_value=16'h0000, o_dp=4'h0, o_blank=4'hF, o_frameValid=0, o_fontErr=0, o_stale=0; shadows=0, mask=0, counters=0, input registers = 4'hF / 8'hFF.
REQ-027 Reset mid-frame SHALL discard partial captures; the first frame after release requires all four digits anew.

Verification
REQ-028 Scan digits 0..3 with fonts C0,F9,A4,B0, each held 8 cycles -> one o_frameValid pulse, o_value=16'h3210, o_dp=0, o_blank=0.
REQ-029 Hold a digit only STABLE_CYCLES-1 cycles -> no capture, mask unchanged, no frameValid.
REQ-030 Font 8'hFF on digit 2 with 7F... pattern 8'h7F (dp lit, blank) -> o_blank[2]=1, o_dp[2]=1, value nibble 0; font 8'hAA -> o_fontErr single pulse, no frame until digit retried.
REQ-031 i_digit=4'b0011 mid-hold -> counter cleared, capture delayed by a full STABLE_CYCLES.
REQ-032 No frames for TIMEOUT_CYCLES (param 50) -> o_stale=1 on cycle 50; next frame clears it in the o_frameValid cycle.
REQ-033 Assert i_reset after 3 digits captured, release, scan 4 digits -> exactly one frame, containing only post-reset values.
